// File: rtl/sdio_cardpwr_pkg.sv
// ---------------------------------------------------------------------------
// sdio_cardpwr_pkg
//   Shared definitions for the card-slot power/presence sequencer:
//   FSM state encodings (S_OFF..S_DRAIN, encoded 0..4, also visible on the
//   debug state output) and a small helper used for counter sizing.
// ---------------------------------------------------------------------------
package sdio_cardpwr_pkg;

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_RAMP  = 3'd1,
    S_RST   = 3'd2,
    S_READY = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sdio_cardpwr_if.sv
// ---------------------------------------------------------------------------
// sdio_cardpwr_if
//   Slot-side and controller-side signals of the card power sequencer.
//   slave  : the sequencer (consumes pin/requests, drives power/reset/detect)
//   master : whoever drives the pin and requests (board / controller / bench)
//   Signals:
//     i_card_detect  raw async card-detect pin
//     i_force_off    software power-off request (level)
//     i_1p8v_req     1.8V request from controller
//     o_card_detect  clean presence to controller
//     o_card_pwr     card rail enable
//     o_vsel_1p8     regulator select, 1 = 1.8V
//     o_sdio_reset   active-high controller reset
//     o_state        FSM state (debug)
//     o_int/i_int_ack  presence-change interrupt, only with SDIO_CARDPWR_IRQ_EN
// ---------------------------------------------------------------------------
interface sdio_cardpwr_if;

  logic       i_card_detect;
  logic       i_force_off;
  logic       i_1p8v_req;
  logic       o_card_detect;
  logic       o_card_pwr;
  logic       o_vsel_1p8;
  logic       o_sdio_reset;
  logic [2:0] o_state;
`ifdef SDIO_CARDPWR_IRQ_EN
  logic       o_int;
  logic       i_int_ack;

  modport slave (
    input  i_card_detect, i_force_off, i_1p8v_req, i_int_ack,
    output o_card_detect, o_card_pwr, o_vsel_1p8, o_sdio_reset, o_state, o_int
  );

  modport master (
    output i_card_detect, i_force_off, i_1p8v_req, i_int_ack,
    input  o_card_detect, o_card_pwr, o_vsel_1p8, o_sdio_reset, o_state, o_int
  );
`else
  modport slave (
    input  i_card_detect, i_force_off, i_1p8v_req,
    output o_card_detect, o_card_pwr, o_vsel_1p8, o_sdio_reset, o_state
  );

  modport master (
    output i_card_detect, i_force_off, i_1p8v_req,
    input  o_card_detect, o_card_pwr, o_vsel_1p8, o_sdio_reset, o_state
  );
`endif

endinterface

// File: rtl/sdio_cardpwr_debounce.sv
// ---------------------------------------------------------------------------
// sdio_cardpwr_debounce
//   2-FF synchroniser, polarity fix and stability filter for a slow
//   mechanical pin (card detect; equally usable for write-protect).
//   The filtered level changes only after the synchronised level has
//   differed from it continuously long enough for the LGDEBOUNCE-bit
//   counter to reach all-ones.
//   Ports:
//     i_clk, i_reset_n  clock, synchronous active-low reset
//     i_raw             raw asynchronous pin
//     o_debounced       filtered level, 1 = asserted (card present)
//   Parameters:
//     LGDEBOUNCE  filter counter width
//     OPT_CD_LOW  1: pin is active-low
// ---------------------------------------------------------------------------
module sdio_cardpwr_debounce #(
  parameter int unsigned LGDEBOUNCE = 20,
  parameter bit          OPT_CD_LOW = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_raw,
  output logic o_debounced
);

  // Raw pin level that means "not asserted"; the synchroniser resets to it
  // so leaving reset never looks like an edge.
  localparam logic RAW_IDLE = OPT_CD_LOW;

  logic [1:0]            sync_q;
  logic [LGDEBOUNCE-1:0] cnt_q;
  logic                  deb_q;
  logic                  synced;

  assign synced = sync_q[1] ^ RAW_IDLE;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      sync_q <= {2{RAW_IDLE}};
      cnt_q  <= '0;
      deb_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], i_raw};
      if (synced == deb_q) begin
        // Agreement (or a bounce back) restarts the stability window.
        cnt_q <= '0;
      end else if (&cnt_q) begin
        deb_q <= synced;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign o_debounced = deb_q;

endmodule

// File: rtl/sdio_cardpwr.sv
// ---------------------------------------------------------------------------
// sdio_cardpwr
//   Card-slot power/presence sequencer sitting upstream of the SD/eMMC
//   controller. Debounces card detect, ramps the card rail, holds the
//   controller in reset until the rail is stable, then presents a clean
//   card-detect and follows 1.8V select requests. Removal or software off
//   always discharges the rail for a full ramp time before re-power.
//   Ports:
//     i_clk, i_reset_n  clock, synchronous active-low reset
//     bus (slave)       pin, requests, power/reset/detect/vsel outputs,
//                       debug state, optional interrupt
//   Parameters:
//     LGDEBOUNCE  presence stability filter width
//     PWR_RAMP    rail ramp cycles, also rail discharge cycles
//     RST_HOLD    controller reset hold after ramp (>=1)
//     OPT_CD_LOW  1: raw detect pin is active-low
//   Build option:
//     SDIO_CARDPWR_IRQ_EN  adds o_int (set on either presence edge, cleared
//                          by i_int_ack, set wins) and the edge logic.
// ---------------------------------------------------------------------------
module sdio_cardpwr
  import sdio_cardpwr_pkg::*;
#(
  parameter int unsigned LGDEBOUNCE = 20,
  parameter int unsigned PWR_RAMP   = 250000,
  parameter int unsigned RST_HOLD   = 16,
  parameter bit          OPT_CD_LOW = 1'b1
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  sdio_cardpwr_if.slave  bus
);

  localparam int unsigned CW = $clog2(max_u(PWR_RAMP, RST_HOLD) + 1);
  localparam logic [CW-1:0] RAMP_LOAD = CW'(PWR_RAMP - 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(RST_HOLD - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pwr_q, pwr_d;
  logic          rst_q, rst_d;
  logic          cd_q, cd_d;
  logic          vsel_q, vsel_d;
  logic          present;
  logic          drop;

  sdio_cardpwr_debounce #(
    .LGDEBOUNCE (LGDEBOUNCE),
    .OPT_CD_LOW (OPT_CD_LOW)
  ) u_debounce (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_raw       (bus.i_card_detect),
    .o_debounced (present)
  );

  // Software off outranks presence: either one tears a powered slot down.
  assign drop = !present || bus.i_force_off;

  // NOTE: every signal assigned in this always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;

    unique case (state_q)
      S_OFF: begin
        cnt_d = '0;
        if (present && !bus.i_force_off) begin
          state_d = S_RAMP;
          cnt_d   = RAMP_LOAD;
        end
      end
      S_RAMP: begin
        if (drop) begin
          state_d = S_DRAIN;
          cnt_d   = RAMP_LOAD;
        end else if (cnt_q == '0) begin
          state_d = S_RST;
          cnt_d   = HOLD_LOAD;
        end
      end
      S_RST: begin
        if (drop) begin
          state_d = S_DRAIN;
          cnt_d   = RAMP_LOAD;
        end else if (cnt_q == '0) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        if (drop) begin
          state_d = S_DRAIN;
          cnt_d   = RAMP_LOAD;
        end
      end
      S_DRAIN: begin
        // Runs to completion regardless of presence; re-power only via OFF.
        if (cnt_q == '0) state_d = S_OFF;
      end
      default: begin
        state_d = S_OFF;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the current state, so they follow a state
    // change by one cycle and are glitch-free at the regulator.
    pwr_d  = (state_q == S_RAMP) || (state_q == S_RST) || (state_q == S_READY);
    rst_d  = (state_q != S_READY);
    cd_d   = (state_q == S_READY);
    vsel_d = (state_q == S_READY) && (vsel_q || bus.i_1p8v_req);
  end

  // NOTE: reset is synchronous and covers every flop here; there are no
  // memories, so nothing is left to power up undefined.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      pwr_q   <= 1'b0;
      rst_q   <= 1'b1;
      cd_q    <= 1'b0;
      vsel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pwr_q   <= pwr_d;
      rst_q   <= rst_d;
      cd_q    <= cd_d;
      vsel_q  <= vsel_d;
    end
  end

  assign bus.o_card_pwr    = pwr_q;
  assign bus.o_sdio_reset  = rst_q;
  assign bus.o_card_detect = cd_q;
  assign bus.o_vsel_1p8    = vsel_q;
  assign bus.o_state       = state_q;

`ifdef SDIO_CARDPWR_IRQ_EN
  logic pres_prev_q;
  logic int_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      pres_prev_q <= 1'b0;
      int_q       <= 1'b0;
    end else begin
      pres_prev_q <= present;
      // A fresh edge wins over an acknowledge in the same cycle.
      int_q       <= (present != pres_prev_q) || (int_q && !bus.i_int_ack);
    end
  end

  assign bus.o_int = int_q;
`endif

endmodule
